vga_scan_ctrl: RTL



---
 rtl/vga_timing_pkg.sv | 63 ++++++
 rtl/scan_counter.sv | 57 +++++
 rtl/vga_scan_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared 640x480@60 timing constants, counter/address widths and the small
//   video-control bundle used by the scan controller and by the capture and
//   convolution blocks that read the same frame buffer.
//
//   Contents:
//     DEF_*          default horizontal/vertical timing (clocks / lines)
//     *_SYNC_FIRST/LAST  default sync-pulse bounds derived from the timing
//     DEF_FB_W       frame-buffer width in pixels (320, upscaled 2x)
//     CNT_W, ADDR_W  scan-counter width and frame-buffer address width
//     vid_ctl_t      {nblank, hsync, vsync} bundle carried down the pipeline
//     VID_CTL_IDLE   inactive value of that bundle (blank, syncs high)
//     in_window()    inclusive range test used for the sync decodes
// ----------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Vertical timing, in lines.
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync pulse bounds (inclusive) for the default timing.
  localparam int DEF_H_SYNC_FIRST = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_LAST  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_FIRST = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_LAST  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC - 1;

  // Frame buffer: 320x240, each pixel shown as a 2x2 block.
  localparam int DEF_FB_W = 320;

  // Widths: counters must hold H_TOTAL-1 (799) and V_TOTAL-1 (524);
  // the address must hold 320*240-1 = 76799.
  localparam int CNT_W  = 10;
  localparam int ADDR_W = 17;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Display-area flag and both syncs travel together so they stay aligned.
  typedef struct packed {
    logic nblank;
    logic hsync;
    logic vsync;
  } vid_ctl_t;

  localparam vid_ctl_t VID_CTL_IDLE = '{nblank: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // Inclusive window compare on a scan counter.
  function automatic logic in_window(input cnt_t c, input cnt_t first, input cnt_t last);
    return (c >= first) && (c <= last);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// ----------------------------------------------------------------------------
// scan_counter
//   Raster position counters. hcnt runs 0..H_TOTAL-1 on every enabled clock;
//   vcnt advances when hcnt wraps and itself wraps after V_TOTAL-1. With en low
//   both counters are held at 0 so the scan restarts at the top-left corner.
//
//   Ports:
//     clk        in   pixel clock
//     rst        in   asynchronous active-high reset
//     en         in   scan enable; 0 clears and holds the counters
//     hcnt       out  current pixel column (S0)
//     vcnt       out  current line (S0)
//     line_end   out  strobe: this clock is the last pixel of the line
//     frame_end  out  strobe: this clock is the last pixel of the frame
// ----------------------------------------------------------------------------
module scan_counter
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             line_end,
  output logic             frame_end
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  // The strobes are qualified with en so downstream line-advance logic never
  // sees a wrap while the scan is parked.
  assign line_end  = en && (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register in
  // the design samples the pre-edge value of its neighbours, independent of
  // the order in which the simulator evaluates the blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= frame_end ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// ----------------------------------------------------------------------------
// vga_scan_ctrl
//   VGA raster scan for a 320x240 frame buffer shown 2x upscaled at 640x480.
//   Stage S0 is the raster position from scan_counter. S1 registers the
//   frame-buffer read address; the RAM returns data one clock later, so the
//   display-area flag and both syncs go through two registers to line up with
//   that data at the RGB stage.
//
//   Ports:
//     clk         in   25 MHz pixel clock (only clock)
//     rst         in   asynchronous active-high reset
//     en          in   scan enable; 0 parks the scan at (0,0) with idle outputs
//     rd_addr     out  frame-buffer read address (S1 register), 0 in blanking
//     Nblank      out  1 while the pixel is in the visible area (aligned to data)
//     hsync       out  horizontal sync, active-low (aligned to data)
//     vsync       out  vertical sync, active-low (aligned to data)
//     frame_done  out  one-clock pulse at the start of vertical blanking
// ----------------------------------------------------------------------------
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int FB_W     = DEF_FB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              Nblank,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t  H_ACT     = cnt_t'(H_ACTIVE);
  localparam cnt_t  V_ACT     = cnt_t'(V_ACTIVE);
  localparam cnt_t  HS_FIRST  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t  HS_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t  VS_FIRST  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t  VS_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam addr_t FB_STRIDE = addr_t'(FB_W);

  // --------------------------------------------------------------------------
  // S0: raster position
  // --------------------------------------------------------------------------
  cnt_t hcnt;
  cnt_t vcnt;
  logic line_end;
  logic frame_end;

  scan_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // --------------------------------------------------------------------------
  // S0 decode: visible area and raw (pre-pipeline) syncs
  // --------------------------------------------------------------------------
  logic     active;
  vid_ctl_t ctl_s0;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    active        = 1'b0;
    ctl_s0        = VID_CTL_IDLE;
    active        = (hcnt < H_ACT) && (vcnt < V_ACT);
    ctl_s0.nblank = active;
    ctl_s0.hsync  = !in_window(hcnt, HS_FIRST, HS_LAST);
    ctl_s0.vsync  = !in_window(vcnt, VS_FIRST, VS_LAST);
  end

  // --------------------------------------------------------------------------
  // Address generation without a multiplier.
  // line_base tracks (vcnt >> 1) * FB_W: it steps by one buffer row each time
  // an odd line finishes (two display lines per buffer row) and returns to 0
  // with the frame wrap. Past the visible area it keeps stepping, but the
  // address is forced to 0 there, so the extra rows are never used.
  // --------------------------------------------------------------------------
  addr_t line_base;
  addr_t addr_s0;

  assign addr_s0 = line_base + addr_t'(hcnt >> 1);

  // NOTE: rst clears asynchronously; en low clears synchronously on the next
  // clock, so a parked scan and a reset one look identical downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_base <= '0;
    end else if (!en) begin
      line_base <= '0;
    end else if (frame_end) begin
      line_base <= '0;
    end else if (line_end && vcnt[0]) begin
      line_base <= line_base + FB_STRIDE;
    end
  end

  // S1: registered read address, zero outside the visible area.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
    end else if (!en) begin
      rd_addr <= '0;
    end else begin
      rd_addr <= active ? addr_s0 : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Control pipeline: S0 -> S1 -> S2. S2 lines up with RAM data, which
  // arrives one clock after rd_addr.
  // --------------------------------------------------------------------------
  vid_ctl_t ctl_s1;
  vid_ctl_t ctl_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_s1 <= VID_CTL_IDLE;
      ctl_s2 <= VID_CTL_IDLE;
    end else if (!en) begin
      ctl_s1 <= VID_CTL_IDLE;
      ctl_s2 <= VID_CTL_IDLE;
    end else begin
      ctl_s1 <= ctl_s0;
      ctl_s2 <= ctl_s1;
    end
  end

  assign Nblank = ctl_s2.nblank;
  assign hsync  = ctl_s2.hsync;
  assign vsync  = ctl_s2.vsync;

  // --------------------------------------------------------------------------
  // frame_done: high for the clock after S0 sits at (0, V_ACTIVE). A reset
  // before that point restarts the scan at line 0, so an aborted frame never
  // reaches the decode and produces no pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else if (!en) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (hcnt == '0) && (vcnt == V_ACT);
    end
  end

endmodule
